jellyvl_etherneco_synctimer_slave_ctl: RTL
==========================================

Name: jellyvl_etherneco_synctimer_slave_ctl

Overview:
- Second-generation Wishbone control/status block for the EtherNeco sync-timer slave. It sits between the CPU bus and the slave timing core.
- Holds correction parameters with non-zero reset defaults and drives override controls to the core.
- Provides atomic multi-word snapshots of local and corrected time, plus a correction-renew counter.
- Adds CAPTURE_NUM timestamp-capture channels with overflow tracking and an interrupt.

Parameters:
- TIMER_WIDTH, 64, timer width; 1..2*WB_DAT_WIDTH.
- LIMIT_WIDTH, 32, limit width; ≤ WB_DAT_WIDTH.
- ERROR_WIDTH, 32, adjust-bound width; ≤ WB_DAT_WIDTH.
- ADJUST_WIDTH, 48, override value width; ≤ 2*WB_DAT_WIDTH.
- CAPTURE_NUM, 2, number of capture channels; 1..16.
- WB_ADR_WIDTH, 16, word-address width.
- WB_DAT_WIDTH, 32, data width; must be 32.
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width.
- INIT_LIMIT_MIN, -100000, reset value of param_limit_min.
- INIT_LIMIT_MAX, +100000, reset value of param_limit_max.
- INIT_ADJUST_MIN, -1000, reset value of param_adjust_min.
- INIT_ADJUST_MAX, +1000, reset value of param_adjust_max.
- CORE_ID, 32'hffff1123, ID register value.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- s_wb_adr_i  in  WB_ADR_WIDTH  word address.
- s_wb_dat_o  out  WB_DAT_WIDTH  read data.
- s_wb_dat_i  in  WB_DAT_WIDTH  write data.
- s_wb_sel_i  in  WB_SEL_WIDTH  byte enables.
- s_wb_we_i  in  1  write enable.
- s_wb_stb_i  in  1  strobe.
- s_wb_ack_o  out  1  acknowledge.
- current_time  in  TIMER_WIDTH  local timer from core.
- monitor_correct_time  in  TIMER_WIDTH  last corrected time.
- monitor_correct_renew  in  1  one-cycle pulse per correction.
- monitor_correct_valid  in  1  core locked.
- capture_trig  in  CAPTURE_NUM  per-channel trigger level (clk domain).
- param_limit_min, param_limit_max  out  LIMIT_WIDTH  limit bounds.
- param_adjust_min, param_adjust_max  out  ERROR_WIDTH  adjust bounds.
- override_en  out  1  override enable.
- override_value  out  ADJUST_WIDTH  override value.
- irq  out  1  capture interrupt, registered.

Behaviour:
- Bus timing:
  - s_wb_ack_o = s_wb_stb_i, zero wait states.
  - Read data is combinational from s_wb_adr_i; unmapped addresses read 0.
  - A write takes effect on the clk edge where stb&we; bytes are masked per sel.
  - Any field narrower than 32 bits is truncated on write and zero-extended on read.
  - Signed fields are stored raw.
- Register map (word addresses):
  - 0x00 ID (RO).
  - 0x01 CAPTURE_NUM (RO).
  - 0x10 SNAPSHOT (WO): a write of any data/sel latches current_time→snap_local and monitor_correct_time→snap_correct on the same edge.
  - 0x20 STATUS:
    - bit0 = monitor_correct_valid (live).
    - bit1 = sticky renew flag; writing 1 to bit1 clears it.
    - A renew pulse in the same cycle as the clear wins, so the flag stays 1.
  - 0x21 RENEW_COUNT:
    - 32-bit, +1 per renew pulse, wraps 0xffffffff→0.
    - Any write clears it; a simultaneous renew pulse leaves the count at 1.
  - 0x22/0x23 snap_correct LO/HI; 0x24/0x25 snap_local LO/HI (RO).
  - 0x30 OVERRIDE_EN (bit0).
  - 0x31/0x32 OVERRIDE_VALUE LO/HI.
  - 0x40–0x43: LIMIT_MIN, LIMIT_MAX, ADJUST_MIN, ADJUST_MAX.
  - 0x50 CAP_STATUS (bits c = valid, bits 16+c = overflow): writing 1 to bit c clears valid[c] and ovf[c].
  - 0x51 CAP_IRQ_EN (bits c).
  - 0x60+2c / 0x61+2c: capture c LO/HI.
- Outputs are driven directly from their registers (0 latency after write).
- Reset values:
  - param outputs = INIT_* values.
  - override_en = 0, override_value = 0.
  - snapshots = 0, counter = 0, flags = 0, irq_en = 0, captures = 0, irq = 0.
  - s_wb_dat_o and s_wb_ack_o follow their combinational rules during reset.
- Capture channel c:
  - Edge detect: rise = trig & ~prev; prev resets to 1, so a level held high through reset does not fire.
  - Rise with valid=0: capture current_time, set valid.
  - Rise with valid=1: keep first value, set ovf.
  - Rise in the same cycle as a clear: load new time, valid=1, ovf=0.
  - Channels are independent; simultaneous rises all capture the same time.
- irq <= |(valid & irq_en), registered (1 cycle after cause); it drops the cycle after clear or disable.
- Reset mid-transaction: the write is discarded and all registers return to reset values.

Test Plan:
- Reset → read 0x40 = 0xfffe7960, 0x41 = 0x000186a0, 0x42 = 0xfffffc18, 0x43 = 0x3e8; 0x00 = 0xffff1123; irq = 0; override_en = 0.
- current_time = 0x0000_0012_3456_789a, write 0x10; timer advances → 0x24 = 0x3456789a, 0x25 = 0x12, stable until the next snapshot.
- Write 0x31 = 0xdeadbeef with sel = 4'b0011 → override_value[31:0] = 0x0000beef; write 0x32 = 0x1234 → override_value = 0x1234_0000beef.
- Three renew pulses → 0x21 = 3, STATUS bit1 = 1; write 0x20 = 2 in the same cycle as a renew → bit1 stays 1; write 0x21 while a renew occurs → 0x21 = 1.
- Enable irq ch0 (0x51 = 1), rise trig[0] at time 1000 → valid, capture = 1000, irq = 1 one cycle later; second rise at 1500 → capture stays 1000, ovf = 1; write 0x50 = 1 → status 0, irq = 0 next cycle.
- trig[1] held high across reset → no capture; rise on trig[1] coincident with clear of ch1 → capture loaded, valid = 1, ovf = 0.

Source files
------------

// File: rtl/jellyvl_etherneco_synctimer_slave_ctl.sv
// jellyvl_etherneco_synctimer_slave_ctl: Wishbone control/status, snapshots and capture channels for the sync-timer slave
module jellyvl_etherneco_synctimer_slave_ctl #(
   parameter int                         TIMER_WIDTH     = 64,
   parameter int                         LIMIT_WIDTH     = 32,
   parameter int                         ERROR_WIDTH     = 32,
   parameter int                         ADJUST_WIDTH    = 48,
   parameter int                         CAPTURE_NUM     = 2,
   parameter int                         WB_ADR_WIDTH    = 16,
   parameter int                         WB_DAT_WIDTH    = 32,
   parameter int                         WB_SEL_WIDTH    = WB_DAT_WIDTH / 8,
   parameter int                         INIT_LIMIT_MIN  = -100000,
   parameter int                         INIT_LIMIT_MAX  = 100000,
   parameter int                         INIT_ADJUST_MIN = -1000,
   parameter int                         INIT_ADJUST_MAX = 1000,
   parameter logic [WB_DAT_WIDTH-1:0]    CORE_ID         = 32'hffff1123
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WB_ADR_WIDTH-1:0]       s_wb_adr_i,
   output logic [WB_DAT_WIDTH-1:0]       s_wb_dat_o,
   input  logic [WB_DAT_WIDTH-1:0]       s_wb_dat_i,
   input  logic [WB_SEL_WIDTH-1:0]       s_wb_sel_i,
   input  logic                          s_wb_we_i,
   input  logic                          s_wb_stb_i,
   output logic                          s_wb_ack_o,
   input  logic [TIMER_WIDTH-1:0]        current_time,
   input  logic [TIMER_WIDTH-1:0]        monitor_correct_time,
   input  logic                          monitor_correct_renew,
   input  logic                          monitor_correct_valid,
   input  logic [CAPTURE_NUM-1:0]        capture_trig,
   output logic [LIMIT_WIDTH-1:0]        param_limit_min,
   output logic [LIMIT_WIDTH-1:0]        param_limit_max,
   output logic [ERROR_WIDTH-1:0]        param_adjust_min,
   output logic [ERROR_WIDTH-1:0]        param_adjust_max,
   output logic                          override_en,
   output logic [ADJUST_WIDTH-1:0]       override_value,
   output logic                          irq
);
   localparam int DW = WB_DAT_WIDTH;
   localparam int XW = 2 * WB_DAT_WIDTH;

   logic                   wr;
   logic [DW-1:0]          be_mask;
   logic [DW-1:0]          wdat;
   logic [TIMER_WIDTH-1:0] snap_local;
   logic [TIMER_WIDTH-1:0] snap_correct;
   logic                   renew_flag;
   logic [31:0]            renew_count;
   logic [CAPTURE_NUM-1:0] cap_valid;
   logic [CAPTURE_NUM-1:0] cap_ovf;
   logic [CAPTURE_NUM-1:0] cap_irq_en;
   logic [CAPTURE_NUM-1:0] trig_prev;
   logic [CAPTURE_NUM-1:0] rise;
   logic [CAPTURE_NUM-1:0] cap_clr;
   logic [TIMER_WIDTH-1:0] cap_time [CAPTURE_NUM];
   logic [XW-1:0]          cap_x    [CAPTURE_NUM];
   logic [XW-1:0]          ov_x;
   logic [XW-1:0]          sl_x;
   logic [XW-1:0]          sc_x;

   assign s_wb_ack_o = s_wb_stb_i;
   assign wr         = s_wb_stb_i & s_wb_we_i;
   assign wdat       = s_wb_dat_i & be_mask;
   assign ov_x       = XW'(override_value);
   assign sl_x       = XW'(snap_local);
   assign sc_x       = XW'(snap_correct);
   assign rise       = capture_trig & ~trig_prev;

   always_comb begin
      be_mask = '0;
      for (int i = 0; i < WB_SEL_WIDTH; i++) be_mask[8*i +: 8] = {8{s_wb_sel_i[i]}};
   end

   always_comb begin
      for (int c = 0; c < CAPTURE_NUM; c++) cap_x[c] = XW'(cap_time[c]);
   end

   function automatic logic wr_at(input int a);
      return wr && (32'(s_wb_adr_i) == a);
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old);
      return (old & ~be_mask) | wdat;
   endfunction

   assign cap_clr = wr_at('h50) ? wdat[CAPTURE_NUM-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         param_limit_min  <= LIMIT_WIDTH'(INIT_LIMIT_MIN);
         param_limit_max  <= LIMIT_WIDTH'(INIT_LIMIT_MAX);
         param_adjust_min <= ERROR_WIDTH'(INIT_ADJUST_MIN);
         param_adjust_max <= ERROR_WIDTH'(INIT_ADJUST_MAX);
         override_en      <= 1'b0;
         override_value   <= '0;
         snap_local       <= '0;
         snap_correct     <= '0;
         renew_flag       <= 1'b0;
         renew_count      <= '0;
         cap_valid        <= '0;
         cap_ovf          <= '0;
         cap_irq_en       <= '0;
         trig_prev        <= '1;
         cap_time         <= '{default: '0};
         irq              <= 1'b0;
      end else begin
         if (wr_at('h40)) param_limit_min  <= LIMIT_WIDTH'(merge(DW'(param_limit_min)));
         if (wr_at('h41)) param_limit_max  <= LIMIT_WIDTH'(merge(DW'(param_limit_max)));
         if (wr_at('h42)) param_adjust_min <= ERROR_WIDTH'(merge(DW'(param_adjust_min)));
         if (wr_at('h43)) param_adjust_max <= ERROR_WIDTH'(merge(DW'(param_adjust_max)));
         if (wr_at('h30)) override_en      <= s_wb_sel_i[0] ? s_wb_dat_i[0] : override_en;
         if (wr_at('h31)) override_value   <= ADJUST_WIDTH'({ov_x[XW-1:DW], merge(ov_x[DW-1:0])});
         if (wr_at('h32)) override_value   <= ADJUST_WIDTH'({merge(ov_x[XW-1:DW]), ov_x[DW-1:0]});
         if (wr_at('h51)) cap_irq_en       <= CAPTURE_NUM'(merge(DW'(cap_irq_en)));
         if (wr_at('h10)) begin
            snap_local   <= current_time;
            snap_correct <= monitor_correct_time;
         end
         // a renew pulse coinciding with the clear keeps the flag set
         renew_flag  <= monitor_correct_renew | (renew_flag & ~(wr_at('h20) & wdat[1]));
         renew_count <= (wr_at('h21) ? '0 : renew_count) + 32'(monitor_correct_renew);
         trig_prev   <= capture_trig;
         for (int c = 0; c < CAPTURE_NUM; c++) begin
            if (rise[c] && (cap_clr[c] || !cap_valid[c])) begin
               cap_time[c]  <= current_time;
               cap_valid[c] <= 1'b1;
               cap_ovf[c]   <= 1'b0;
            end else if (rise[c]) begin
               cap_ovf[c]   <= 1'b1;
            end else if (cap_clr[c]) begin
               cap_valid[c] <= 1'b0;
               cap_ovf[c]   <= 1'b0;
            end
         end
         irq <= |(cap_valid & cap_irq_en);
      end
   end

   always_comb begin
      s_wb_dat_o = '0;
      case (32'(s_wb_adr_i))
         'h00: s_wb_dat_o = CORE_ID;
         'h01: s_wb_dat_o = DW'(CAPTURE_NUM);
         'h20: s_wb_dat_o = DW'({renew_flag, monitor_correct_valid});
         'h21: s_wb_dat_o = renew_count;
         'h22: s_wb_dat_o = sc_x[DW-1:0];
         'h23: s_wb_dat_o = sc_x[XW-1:DW];
         'h24: s_wb_dat_o = sl_x[DW-1:0];
         'h25: s_wb_dat_o = sl_x[XW-1:DW];
         'h30: s_wb_dat_o = DW'(override_en);
         'h31: s_wb_dat_o = ov_x[DW-1:0];
         'h32: s_wb_dat_o = ov_x[XW-1:DW];
         'h40: s_wb_dat_o = DW'(param_limit_min);
         'h41: s_wb_dat_o = DW'(param_limit_max);
         'h42: s_wb_dat_o = DW'(param_adjust_min);
         'h43: s_wb_dat_o = DW'(param_adjust_max);
         'h50: s_wb_dat_o = DW'(cap_valid) | (DW'(cap_ovf) << 16);
         'h51: s_wb_dat_o = DW'(cap_irq_en);
         default: s_wb_dat_o = '0;
      endcase
      for (int c = 0; c < CAPTURE_NUM; c++) begin
         if (32'(s_wb_adr_i) == 'h60 + 2*c) s_wb_dat_o = cap_x[c][DW-1:0];
         if (32'(s_wb_adr_i) == 'h61 + 2*c) s_wb_dat_o = cap_x[c][XW-1:DW];
      end
   end
endmodule
